// File: rtl/nonrestoring_divider_pkg.sv
// Shared types for the sequential non-restoring divider: FSM state encoding.
package nonrestoring_divider_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/nonrestoring_divider_if.sv
// Start/done request bundle between a controller (master) and the divider (slave).
interface nonrestoring_divider_if #(
  parameter int WIDTH = 4
);
  import nonrestoring_divider_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_addsub_stage.sv
// Combinational W-bit add/subtract: sum = a + b (sub=0) or a - b (sub=1), carry out dropped.
module div_addsub_stage #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);
  import nonrestoring_divider_pkg::*;

  assign sum = a + (b ^ {W{sub}}) + W'(sub);

endmodule

// File: rtl/nonrestoring_divider.sv
// Unsigned non-restoring divider, one add/sub per cycle; done WIDTH+2 cycles after start, start ignored while busy.
// DIV_ZERO_FAST_EN: a zero divisor skips straight from IDLE to DONE with the all-ones quotient.
module nonrestoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nonrestoring_divider_if.slave div_if
);
  import nonrestoring_divider_pkg::*;

  localparam int RW    = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [RW-1:0]    r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [RW-1:0]    as_a, as_b, as_sum;
  logic             as_sub;
  logic [RW-1:0]    r_shift;
  logic [RW-1:0]    r_fixed;
  logic             zero_shortcut;

`ifdef DIV_ZERO_FAST_EN
  assign zero_shortcut = (div_if.divisor == '0);
`else
  assign zero_shortcut = 1'b0;
`endif

  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  div_addsub_stage #(.W(RW)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .sum (as_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (div_if.start) state_d = zero_shortcut ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_if.busy = (state_q != IDLE);
    div_if.done = (state_q == DONE);
  end

  // The shared stage subtracts while the partial remainder is non-negative, adds otherwise.
  always_comb begin
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    as_a        = r_shift;
    as_b        = {1'b0, d_q};
    as_sub      = ~r_q[WIDTH];
    r_fixed     = r_q;
    case (state_q)
      IDLE: begin
        if (div_if.start) begin
          r_d   = '0;
          q_d   = div_if.dividend;
          d_d   = div_if.divisor;
          cnt_d = CNT_W'(WIDTH - 1);
          if (zero_shortcut) begin
            quotient_d  = '1;
            remainder_d = div_if.dividend;
            dbz_d       = 1'b1;
          end
        end
      end
      CALC: begin
        r_d   = as_sum;
        q_d   = {q_q[WIDTH-2:0], ~as_sum[WIDTH]};
        cnt_d = cnt_q - 1'b1;
      end
      FIX: begin
        as_a        = r_q;
        as_sub      = 1'b0;
        r_fixed     = r_q[WIDTH] ? as_sum : r_q;
        r_d         = r_fixed;
        quotient_d  = q_q;
        remainder_d = r_fixed[WIDTH-1:0];
        dbz_d       = (d_q == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign div_if.quotient    = quotient_q;
  assign div_if.remainder   = remainder_q;
  assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard bench for nonrestoring_divider: expected results queued at start, checked when done pulses.
module tb_nonrestoring_divider;

  localparam int W = 4;

  typedef struct {
    int q;
    int r;
    int dz;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   pushed = 0;
  exp_t sb[$];
  exp_t mon_e;

  nonrestoring_divider_if #(.WIDTH(W)) div_if();

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (div_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, zero divisor gives all-ones / dividend.
  task automatic issue(input int a, input int b, input bit expect_done);
    exp_t e;
    @(posedge clk); #1;
    div_if.start    = 1'b1;
    div_if.dividend = W'(a);
    div_if.divisor  = W'(b);
    if (b == 0) begin
      e.q  = (1 << W) - 1;
      e.r  = a;
      e.dz = 1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 0;
    end
    e.cyc = cyc + W + 2;
`ifdef DIV_ZERO_FAST_EN
    if (b == 0) e.cyc = -1;
`endif
    if (expect_done) begin
      sb.push_back(e);
      pushed++;
    end
    @(posedge clk); #1;
    div_if.start    = 1'b0;
    div_if.dividend = W'($urandom);
    div_if.divisor  = W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_if.done === 1'b1) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL done_timeout: no done within 40 cycles, expected one");
  endtask

  always @(negedge clk) begin
    if (div_if.done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: done at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", div_if.quotient, mon_e.q);
        check("remainder", div_if.remainder, mon_e.r);
        check("div_by_zero", div_if.div_by_zero, mon_e.dz);
        check("busy_in_done", div_if.busy, 1);
        if (mon_e.cyc >= 0) check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order[256];
    int j;
    int tmp;

    div_if.start    = 1'b0;
    div_if.dividend = '0;
    div_if.divisor  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", div_if.busy, 0);
    check("rst_done", div_if.done, 0);
    check("rst_quotient", div_if.quotient, 0);
    check("rst_remainder", div_if.remainder, 0);
    check("rst_dbz", div_if.div_by_zero, 0);
    rst = 1'b0;

    issue(13, 3, 1); wait_done();
    issue(15, 1, 1); wait_done();
    issue(5, 7, 1);  wait_done();
    issue(9, 0, 1);  wait_done();

    // Second start while busy must be dropped.
    issue(12, 5, 1);
    repeat (2) @(posedge clk);
    #1;
    div_if.start    = 1'b1;
    div_if.dividend = 4'd8;
    div_if.divisor  = 4'd2;
    @(posedge clk); #1;
    div_if.start    = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);

    // Reset in the middle of an operation aborts it with no done.
    issue(13, 3, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", div_if.busy, 0);
    check("abort_done", div_if.done, 0);
    check("abort_quotient", div_if.quotient, 0);
    check("abort_remainder", div_if.remainder, 0);
    check("abort_dbz", div_if.div_by_zero, 0);
    repeat (8) @(negedge clk);
    issue(8, 2, 1); wait_done();

    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j        = $urandom_range(i, 0);
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int k = 0; k < 256; k++) begin
      issue(order[k] >> 4, order[k] & 15, 1);
      wait_done();
    end

    repeat (10) @(negedge clk);
    check("done_count", done_seen, pushed);
    check("pending", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
